pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised, elastic chain of pipeline registers with valid/ready flow control, per-stage flush and bubble collapsing. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage core into one block of configurable payload width and depth. Stalls are expressed as backpressure instead of per-register write-disable wires. Per-stage valid and data taps feed the hazard detection and forwarding logic.

## Interface
- WIDTH, 64, payload bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1); stage 0 is youngest, stage DEPTH-1 drives the output
- CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  chain accepts a beat this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage DEPTH-1 holds a live beat
- out_ready  in  1  downstream accepts the beat
- out_data  out  WIDTH  payload of stage DEPTH-1
- flush  in  DEPTH  bit i kills stage i this cycle
- stage_valid  out  DEPTH  effective valid per stage, i.e. `v[i] & ~flush[i]`
- stage_data  out  WIDTH*DEPTH  stage i payload at bits [i*WIDTH +: WIDTH]
- occupancy  out  CW  registered count of valid stages

## Operation
- State per stage i: v[i] (1 bit) and d[i] (WIDTH bits).
- Effective valid: ev[i] = v[i] & ~flush[i]. All forward movement and the output use ev, never raw v.
- Ready chain (combinational): rdy[DEPTH] = out_ready; rdy[i] = ~ev[i] | rdy[i+1]; in_ready = rdy[0].
- Source of stage i: src_v[0] = in_valid, src_d[0] = in_data; for i>0, src_v[i] = ev[i-1], src_d[i] = d[i-1].
- Update at each edge:
  - If rdy[i] = 1: v[i] ← src_v[i] & ~flush[i], and d[i] ← src_d[i] when src_v[i] = 1.
  - Otherwise stage i holds both v[i] and d[i].
- A flushed stage drops its own beat. It also drops any beat that moves into it that edge.
- A flushed stage's old beat never reaches stage i+1 or the output.
- Bubble collapsing: when stage k is stalled, each empty stage below k still accepts from its predecessor, so holes close up toward the output.
- out_valid = ev[DEPTH-1]; out_data = d[DEPTH-1].
- A transfer occurs when out_valid & out_ready. On an input-side handshake, in_valid & in_ready, the beat is consumed even if flush[0] then drops it.
- occupancy ← popcount of next-state v. It does not reflect same-cycle flush combinationally.
- d of invalid stages is don't-care to consumers. It is only written when src_v = 1, to save toggles.

## Timing
- Reset (reset = 0, asynchronous):
  - all v ← 0 and all d ← 0, so out_valid = 0, stage_valid = 0, out_data = 0 and occupancy = 0.
  - in_ready = 1, since it is combinational from empty stages.
- After reset deasserts, the first edge may accept a beat.
- Latency: with no stalls, a beat accepted at edge n is out_valid from edge n+DEPTH-1 until it transfers, i.e. it is visible DEPTH-1 cycles after stage 0 captures it.
- Throughput: one beat per cycle whenever out_ready = 1 continuously.
- Full chain with out_ready = 0:
  - in_ready = 0 and all stages hold.
  - When out_ready returns to 1, in_ready = 1 in the same cycle (combinational pass-through).
- Simultaneous transfer out and in on a full chain: all stages shift by one and occupancy is unchanged.
- Reset mid-operation: all in-flight beats are lost immediately, with no drain.
- DEPTH = 1: out_valid = v[0] & ~flush[0]; in_ready = ~out_valid | out_ready.

## Test plan
- Stream: WIDTH=64, DEPTH=4, out_ready=1, inject 0x10,0x11,0x12 on consecutive cycles -> the same values appear in order on out_data on consecutive cycles, first one 3 cycles after stage 0 capture, and occupancy peaks at 3.
- Fill/backpressure: out_ready=0 with 5 beats offered -> 4 accepted, in_ready=0 and occupancy=4. Then out_ready=1 for 4 cycles -> beats 1..4 out in order, and beat 5 accepted in the first of those cycles.
- Bubble collapse: beats A,_,B,_ with out_ready=0 -> after 2 more edges stage_valid=4'b1100, then 4'b1110 after C is injected. No beat is lost or reordered.
- Flush: stages 1 and 2 hold X and Y, pulse flush=4'b0110 for one cycle with a beat at stage 0 moving in -> X and Y never appear on the output, the stage 0 beat is dropped in stage 1, and occupancy drops accordingly.
- Flush of the output stage: out_valid=1 with out_ready=1 and flush[3]=1 -> out_valid reads 0 that cycle and no transfer is counted.
- Async reset: assert reset=0 between edges on a full chain -> outputs are zero, in_ready=1 and occupancy=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline registers with valid/ready backpressure,
// per-stage flush, bubble collapsing and per-stage taps for hazard logic.
module pipe_stage_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic [DEPTH-1:0]         flush,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [WIDTH*DEPTH-1:0]   stage_data,
    output logic [CW-1:0]            occupancy
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [CW-1:0]    occ_nxt;

    // A flushed stage is treated as empty for movement, output and readiness.
    assign ev = v & ~flush;

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~ev[i] | rdy[i+1];
        end
    end

    always_comb begin
        src_v    = '0;
        src_d    = '{default: '0};
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = ev[i-1];
            src_d[i] = d[i-1];
        end
    end

    always_comb begin
        v_nxt   = v;
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                v_nxt[i] = src_v[i] & ~flush[i];
            end
            occ_nxt = occ_nxt + CW'(v_nxt[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the chain shifts by one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= occ_nxt;
        end
    end

    // NOTE: the payload array is reset because out_data and the taps must read
    // zero out of reset; writes are gated on src_v to avoid needless toggles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i] && src_v[i]) begin
                    d[i] <= src_d[i];
                end
            end
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = ev[DEPTH-1];
    assign out_data    = d[DEPTH-1];
    assign stage_valid = ev;

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign stage_data[g*WIDTH +: WIDTH] = d[g];
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=64, DEPTH=4): streaming, fill and
// backpressure, bubble collapse, flush and asynchronous reset.
module tb_pipe_stage_chain;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [3:0]   flush;
    logic [3:0]   stage_valid;
    logic [255:0] stage_data;
    logic [2:0]   occupancy;

    int n_asserts = 0;
    int n_fails   = 0;

    pipe_stage_chain #(.WIDTH(64), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        flush     = '0;
        #12;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_occupancy", 256'(occupancy), 256'(0));
        check("rst_stage_data", stage_data, 256'(0));
        reset = 1'b1;

        // Stream 0x10,0x11,0x12 with out_ready held high.
        tick();
        in_valid = 1'b1; in_data = 64'h10; tick();
        check("st_sv_e1", 256'(stage_valid), 256'(4'b0001));
        check("st_occ_e1", 256'(occupancy), 256'(1));
        in_data = 64'h11; tick();
        in_data = 64'h12; tick();
        in_valid = 1'b0;
        check("st_occ_e3", 256'(occupancy), 256'(3));
        check("st_ov_e3", 256'(out_valid), 256'(0));
        tick();
        check("st_out0_v", 256'(out_valid), 256'(1));
        check("st_out0", 256'(out_data), 256'(64'h10));
        check("st_occ_e4", 256'(occupancy), 256'(3));
        tick();
        check("st_out1", 256'(out_data), 256'(64'h11));
        check("st_occ_e5", 256'(occupancy), 256'(2));
        tick();
        check("st_out2", 256'(out_data), 256'(64'h12));
        tick();
        check("st_empty", 256'(out_valid), 256'(0));
        check("st_occ_end", 256'(occupancy), 256'(0));

        // Fill with out_ready low: 4 of 5 offered beats accepted.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'h21; tick();
        in_data = 64'h22; tick();
        in_data = 64'h23; tick();
        in_data = 64'h24; tick();
        in_data = 64'h25; settle();
        check("fill_in_ready", 256'(in_ready), 256'(0));
        check("fill_occ", 256'(occupancy), 256'(4));
        check("fill_out", 256'(out_data), 256'(64'h21));
        check("fill_taps", stage_data, {192'(0), 64'h0} | {64'h21, 64'h22, 64'h23, 64'h24});
        tick();
        check("fill_hold_occ", 256'(occupancy), 256'(4));
        check("fill_hold_out", 256'(out_data), 256'(64'h21));
        out_ready = 1'b1; settle();
        check("fill_passthru_rdy", 256'(in_ready), 256'(1));
        tick();
        in_valid = 1'b0;
        check("fill_out2", 256'(out_data), 256'(64'h22));
        check("fill_occ_shift", 256'(occupancy), 256'(4));
        check("fill_s0_beat5", stage_data[63:0], 256'(64'h25));
        tick();
        check("fill_out3", 256'(out_data), 256'(64'h23));
        tick();
        check("fill_out4", 256'(out_data), 256'(64'h24));
        tick();
        check("fill_out5", 256'(out_data), 256'(64'h25));
        tick();
        check("fill_drained", 256'(occupancy), 256'(0));

        // Bubble collapse: A,_,B,_ with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 64'hB; tick();
        in_valid = 1'b0; tick();
        check("bub_sv_e4", 256'(stage_valid), 256'(4'b1010));
        tick();
        tick();
        check("bub_sv_1100", 256'(stage_valid), 256'(4'b1100));
        in_valid = 1'b1; in_data = 64'hC; tick();
        in_valid = 1'b0; tick();
        check("bub_sv_1110", 256'(stage_valid), 256'(4'b1110));
        check("bub_taps", stage_data[255:64], {64'hA, 64'hB, 64'hC});
        check("bub_occ", 256'(occupancy), 256'(3));
        out_ready = 1'b1; settle();
        check("bub_outA", 256'(out_data), 256'(64'hA));
        tick();
        check("bub_outB", 256'(out_data), 256'(64'hB));
        tick();
        check("bub_outC", 256'(out_data), 256'(64'hC));
        tick();
        check("bub_empty", 256'(out_valid), 256'(0));

        // Flush stages 1 and 2 while stage 0 moves into stage 1.
        in_valid = 1'b1; in_data = 64'h51; tick();
        in_data = 64'h52; tick();
        in_data = 64'h53; tick();
        in_valid = 1'b0;
        check("fl_pre_sv", 256'(stage_valid), 256'(4'b0111));
        check("fl_pre_occ", 256'(occupancy), 256'(3));
        flush = 4'b0110; settle();
        check("fl_ev", 256'(stage_valid), 256'(4'b0001));
        tick();
        flush = '0;
        check("fl_occ", 256'(occupancy), 256'(0));
        check("fl_sv", 256'(stage_valid), 256'(4'b0000));
        tick();
        check("fl_ov1", 256'(out_valid), 256'(0));
        tick();
        check("fl_ov2", 256'(out_valid), 256'(0));

        // Flush of the output stage while out_ready is high.
        in_valid = 1'b1; in_data = 64'h77; tick();
        in_valid = 1'b0; tick(); tick(); tick();
        check("flo_pre_ov", 256'(out_valid), 256'(1));
        flush = 4'b1000; settle();
        check("flo_ov", 256'(out_valid), 256'(0));
        check("flo_in_ready", 256'(in_ready), 256'(1));
        tick();
        flush = '0; settle();
        check("flo_occ", 256'(occupancy), 256'(0));
        check("flo_ov_after", 256'(out_valid), 256'(0));

        // Asynchronous reset on a full chain, between edges.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h91; tick();
        in_data = 64'h92; tick();
        in_data = 64'h93; tick();
        in_data = 64'h94; tick();
        in_valid = 1'b0;
        check("ar_full_occ", 256'(occupancy), 256'(4));
        #2;
        reset = 1'b0;
        #1;
        check("ar_occ", 256'(occupancy), 256'(0));
        check("ar_out_valid", 256'(out_valid), 256'(0));
        check("ar_out_data", 256'(out_data), 256'(0));
        check("ar_in_ready", 256'(in_ready), 256'(1));
        check("ar_stage_data", stage_data, 256'(0));
        #1;
        reset = 1'b1;
        tick();
        check("ar_stays_empty", 256'(occupancy), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
